// File: rtl/cube_state_packer.sv
// Packs a 48-element fixed-point cube-state tensor into the 120-bit cube encoding, one element per cycle.
// Optional macro CUBE_PACK_ROUND_EN selects round-half-up instead of floor before the fractional shift.
module cube_state_packer #(
  parameter int DATA_LEN = 16,
  parameter int DATA_DEC = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [48*DATA_LEN-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [119:0]            out_data,
  output logic                    sat_err
);

  localparam int EW = DATA_LEN + 1;
  localparam int TW = 48 * DATA_LEN;
`ifdef CUBE_PACK_ROUND_EN
  localparam logic [EW-1:0] RND_C = {{(EW-1){1'b0}}, 1'b1} << (DATA_DEC - 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [TW-1:0]       tensor_r;
  logic [5:0]          idx_r;
  logic [119:0]        out_data_r;
  logic                sat_err_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                in_ready_s;
  logic                out_valid_s;
  logic                accept_s;
  logic                pack_last_s;
  logic [1:0]          grp_s;
  logic [3:0]          j_s;
  logic [6:0]          lsb_s;
  logic [3:0]          max_s;
  logic [EW-1:0]       ext_s;
  logic [EW-1:0]       rnd_s;
  logic signed [EW-1:0] shr_s;
  logic [3:0]          fval_s;
  logic                clamp_s;
  logic [119:0]        field_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign sat_err   = sat_err_r;

  assign accept_s    = in_valid && in_ready_r;
  assign pack_last_s = (state_r == PACK) && (idx_r == 6'd47);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = PACK;
        else          state_s = IDLE;
      end
      PACK: begin
        if (pack_last_s) state_s = DONE;
        else             state_s = PACK;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state, then registered
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_s)
      IDLE:    in_ready_s  = 1'b1;
      DONE:    out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Handshake output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Split the element index into field group and slot within the group
  always_comb begin
    grp_s = 2'd0;
    j_s   = 4'd0;
    if (idx_r < 6'd12) begin
      grp_s = 2'd0;
      j_s   = idx_r[3:0];
    end else if (idx_r < 6'd24) begin
      grp_s = 2'd1;
      j_s   = 4'(idx_r - 6'd12);
    end else if (idx_r < 6'd36) begin
      grp_s = 2'd2;
      j_s   = 4'(idx_r - 6'd24);
    end else begin
      grp_s = 2'd3;
      j_s   = 4'(idx_r - 6'd36);
    end
  end

  // Field bit offset and saturation ceiling for the current group
  always_comb begin
    lsb_s = 7'd0;
    max_s = 4'd0;
    case (grp_s)
      2'd0: begin lsb_s = 7'd3 * {3'd0, j_s};          max_s = 4'd7;  end
      2'd1: begin lsb_s = 7'd36 + {2'd0, j_s, 1'b0};   max_s = 4'd3;  end
      2'd2: begin lsb_s = 7'd60 + {1'b0, j_s, 2'b00};  max_s = 4'd15; end
      2'd3: begin lsb_s = 7'd108 + {3'd0, j_s};        max_s = 4'd1;  end
      default: begin lsb_s = 7'd0; max_s = 4'd0; end
    endcase
  end

  // Element conversion: widen, optionally round, drop the fraction, clamp to the field
  always_comb begin
    ext_s = {tensor_r[DATA_LEN-1], tensor_r[DATA_LEN-1:0]};
`ifdef CUBE_PACK_ROUND_EN
    rnd_s = ext_s + RND_C;
`else
    rnd_s = ext_s;
`endif
    shr_s = $signed(rnd_s) >>> DATA_DEC;
    if (shr_s[EW-1]) begin
      fval_s  = 4'd0;
      clamp_s = 1'b1;
    end else if ($unsigned(shr_s) > {{(EW-4){1'b0}}, max_s}) begin
      fval_s  = max_s;
      clamp_s = 1'b1;
    end else begin
      fval_s  = shr_s[3:0];
      clamp_s = 1'b0;
    end
    field_s = {116'd0, fval_s} << lsb_s;
  end

  // Datapath: latch on accept, then consume one element per PACK cycle from the low end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tensor_r   <= '0;
      idx_r      <= 6'd0;
      out_data_r <= 120'd0;
      sat_err_r  <= 1'b0;
    end else if (accept_s) begin
      tensor_r   <= in_data;
      idx_r      <= 6'd0;
      out_data_r <= 120'd0;
      sat_err_r  <= 1'b0;
    end else if (state_r == PACK) begin
      tensor_r   <= tensor_r >> DATA_LEN;
      idx_r      <= pack_last_s ? 6'd0 : idx_r + 6'd1;
      out_data_r <= out_data_r | field_s;
      sat_err_r  <= sat_err_r | clamp_s;
    end
  end

endmodule

// File: tb/tb_cube_state_packer.sv
// Randomised self-checking bench for cube_state_packer against an integer-arithmetic packing model.
module tb_cube_state_packer;

  localparam int DL = 16;
  localparam int DD = 8;
  localparam int TW = 48 * DL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [119:0]  out_data;
  logic          sat_err;

  int checks = 0;
  int errors = 0;

  cube_state_packer #(.DATA_LEN(DL), .DATA_DEC(DD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_err   (sat_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each element to an integer, floor (or round half up) by 2^DD, clamp to its field.
  function automatic logic [120:0] ref_pack(input logic [TW-1:0] t);
    logic [119:0] w;
    logic sat;
    w   = '0;
    sat = 1'b0;
    for (int i = 0; i < 48; i++) begin
      int v, wd, pos, maxv, g, j;
      v = int'($signed(t[i*DL +: DL]));
`ifdef CUBE_PACK_ROUND_EN
      v = v + (1 << (DD - 1));
`endif
      v = v >>> DD;
      g = i / 12;
      j = i % 12;
      case (g)
        0: begin wd = 3; pos = 3 * j; end
        1: begin wd = 2; pos = 36 + 2 * j; end
        2: begin wd = 4; pos = 60 + 4 * j; end
        default: begin wd = 1; pos = 108 + j; end
      endcase
      maxv = (1 << wd) - 1;
      if (v < 0) begin v = 0; sat = 1'b1; end
      else if (v > maxv) begin v = maxv; sat = 1'b1; end
      w = w | (120'(v) << pos);
    end
    return {sat, w};
  endfunction

  function automatic logic [TW-1:0] rand_tensor(input int mode);
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < 48; i++) begin
      logic [DL-1:0] e;
      if (mode == 0) e = 16'($urandom);
      else           e = 16'($urandom_range(0, 32'h0FFF));
      t[i*DL +: DL] = e;
    end
    return t;
  endfunction

  task automatic run_packet(input logic [TW-1:0] t, input int hold, input string tag);
    logic [120:0] e;
    int cnt;
    e   = ref_pack(t);
    cnt = 0;
    while (!in_ready && cnt < 200) begin
      @(posedge clk); #1; cnt++;
    end
    check_val({tag, "_ready"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_data  = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = rand_tensor(0);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(posedge clk); #1; cnt++;
    end
    check_val({tag, "_latency"}, 128'(cnt), 128'd48);
    check_val({tag, "_data"}, 128'(out_data), 128'(e[119:0]));
    check_val({tag, "_sat"}, 128'(sat_err), 128'(e[120]));
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom);
      in_data  = rand_tensor(0);
      @(posedge clk); #1;
      check_val({tag, "_bp_data"}, 128'(out_data), 128'(e[119:0]));
      check_val({tag, "_bp_sat"}, 128'(sat_err), 128'(e[120]));
      check_val({tag, "_bp_rdy"}, 128'(in_ready), 128'd0);
      check_val({tag, "_bp_vld"}, 128'(out_valid), 128'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({tag, "_rel_vld"}, 128'(out_valid), 128'd0);
    check_val({tag, "_rel_rdy"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    logic [TW-1:0] t;
    logic [2:0] rexp;

    // Reset for 3 cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_val("rst_ready", 128'(in_ready), 128'd1);
    check_val("rst_valid", 128'(out_valid), 128'd0);
    check_val("rst_data", 128'(out_data), 128'd0);
    check_val("rst_sat", 128'(sat_err), 128'd0);

    // Integer corner positions
    t = '0;
    for (int j = 0; j < 12; j++) t[j*DL +: DL] = 16'((j % 8) << DD);
    run_packet(t, 0, "int");
    for (int j = 0; j < 12; j++)
      check_val("int_field", 128'(out_data[3*j +: 3]), 128'(j % 8));
    check_val("int_upper", 128'(out_data[119:36]), 128'd0);
    check_val("int_sat0", 128'(sat_err), 128'd0);

    // Saturation high on edge position 0
    t = '0;
    t[24*DL +: DL] = 16'h1400;
    run_packet(t, 0, "sat_hi");
    check_val("sat_hi_field", 128'(out_data[63:60]), 128'd15);
    check_val("sat_hi_flag", 128'(sat_err), 128'd1);

    // Saturation low on corner direction 0
    t = '0;
    t[12*DL +: DL] = 16'hFF00;
    run_packet(t, 0, "sat_lo");
    check_val("sat_lo_field", 128'(out_data[37:36]), 128'd0);
    check_val("sat_lo_flag", 128'(sat_err), 128'd1);

    // Rounding at exactly one half and just below
`ifdef CUBE_PACK_ROUND_EN
    rexp = 3'd3;
`else
    rexp = 3'd2;
`endif
    t = '0;
    t[0 +: DL] = 16'h0280;
    run_packet(t, 0, "rnd_half");
    check_val("rnd_half_field", 128'(out_data[2:0]), 128'(rexp));
    t[0 +: DL] = 16'h027F;
    run_packet(t, 0, "rnd_below");
    check_val("rnd_below_field", 128'(out_data[2:0]), 128'd2);

    // Backpressure with in_valid pulses
    run_packet(rand_tensor(1), 10, "bp");

    // Random packets, mixed ranges
    for (int p = 0; p < 6; p++) run_packet(rand_tensor(p % 2), $urandom_range(0, 3), "rand");

    // Reset in the middle of PACK at index 20
    in_valid = 1'b1;
    in_data  = rand_tensor(0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_val("mid_rst_ready", 128'(in_ready), 128'd1);
    check_val("mid_rst_valid", 128'(out_valid), 128'd0);
    check_val("mid_rst_data", 128'(out_data), 128'd0);
    check_val("mid_rst_sat", 128'(sat_err), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_packet(rand_tensor(1), 1, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cube_state_packer.md
Name: cube_state_packer

Overview:
- Converts a fixed-point cube-state tensor of 48 elements (shape 4,3,4) into the packed 120-bit cube encoding. This is the inverse of the 120-bit-to-fixed-point unpack path.
- Sits between the network output / state-update stage and the 120-bit cube-state bus.
- Processes one element per cycle with saturation and rounding, then holds the packed word under a valid/ready handshake.

Parameters:
- DATA_LEN, 16: width of each fixed-point element, two's complement. Instantiations pass `data_len.
- DATA_DEC, 8: number of fractional bits per element. Instantiations pass `data_dec.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data holds a complete tensor
- in_ready  output  1  block can accept a tensor
- in_data  input  48*DATA_LEN  element i occupies bits [i*DATA_LEN +: DATA_LEN]
- out_valid  output  1  out_data and sat_err are valid
- out_ready  input  1  consumer accepts out_data
- out_data  output  120  packed cube state
- sat_err  output  1  at least one element was clamped in this packet

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, sat_err=0, element index=0, state IDLE. Reset is asynchronous, active-high, and effective at any time, including mid-packet; the partial packet is discarded.
- States:
  - IDLE: in_ready=1.
  - PACK: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: the edge where in_valid&&in_ready. On that edge:
  - latch all of in_data into an internal register;
  - clear out_data and sat_err;
  - set index=0;
  - go to PACK.
- PACK: each edge processes element idx and writes its field into out_data. Field placement, with g=idx/12, j=idx%12:
  - g0: width 3 at bit 3j (corner position)
  - g1: width 2 at bit 36+2j (corner direction)
  - g2: width 4 at bit 60+4j (edge position)
  - g3: width 1 at bit 108+j (edge direction)
- Index 47 moves to DONE on the same edge. out_valid is high after the 48th edge following the accept edge.
- Conversion per element:
  1. Sign-extend the element by 1 bit.
  2. Apply rounding per the optional feature.
  3. Arithmetic shift right by DATA_DEC.
  4. Clamp: a negative result gives 0 and sets sat_err; a result above 2^w-1 gives 2^w-1 and sets sat_err.
- sat_err is sticky from accept to the next accept.
- DONE: out_data and sat_err are held stable. On out_valid&&out_ready, go to IDLE; in_ready=1 from the next cycle. The same edge cannot also accept.
- in_valid is ignored outside IDLE, and the latched tensor is unaffected by later changes to in_data.
- Throughput: one packet per 50 cycles minimum (accept, 48 PACK edges, output handshake).

Optional Feature:
- CUBE_PACK_ROUND_EN defined: add 2^(DATA_DEC-1) before the shift (round half up).
- Undefined: no add; the shift floors the value.
- Clamping and timing are identical in both builds.

Test Plan:
- Reset: assert rst for 3 cycles, then release. Expect in_ready=1, out_valid=0, out_data=0, sat_err=0.
- Integer packet: corner-position element j = (j%8)<<DATA_DEC, all others 0. Expect out_data[35:0] to hold the 3-bit fields 0..7,0..3, out_data[119:36]=0, sat_err=0, out_valid rising exactly 48 edges after accept. Unpacking this word must reproduce the integer parts of the tensor.
- Saturation, in two packets:
  - edge-position element 0 = 20.0 (0x1400) gives field [63:60]=15 and sat_err=1;
  - corner-direction element 0 = -1.0 (0xFF00) gives field [37:36]=0 and sat_err=1.
  - All other elements in range.
- Rounding:
  - corner-position element 0 = 2.5 (0x0280) gives [2:0]=3 with CUBE_PACK_ROUND_EN, 2 without;
  - 0x027F gives 2 in both builds.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises, pulsing in_valid with different data. Expect out_data and sat_err stable and in_ready=0 throughout. After out_ready=1 for one edge, expect out_valid=0 and in_ready=1 next cycle.
- Reset mid-operation: assert rst during PACK at index 20. Expect all outputs at their reset values immediately. Then send a fresh packet and expect the correct full result with no residue from the aborted packet.
